// File: rtl/mdc_r2_stage.sv
// mdc_r2_stage: radix-2 MDC FFT stage; ports: in_valid/scale_en control, in_up/in_lo lanes, tw_addr/tw twiddle fetch, out_valid/out_frame plus out_up sum and out_lo twiddled difference
module mdc_r2_stage #(
  parameter int WIDTH = 9,
  parameter int DELAY = 16,
  parameter int TW_WIDTH = 9,
  parameter int TW_FRAC = 7,
  parameter int TW_ADDR_W = 4,
  parameter int TW_STRIDE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        scale_en,
  input  logic signed [WIDTH-1:0]     in_up_re,
  input  logic signed [WIDTH-1:0]     in_up_im,
  input  logic signed [WIDTH-1:0]     in_lo_re,
  input  logic signed [WIDTH-1:0]     in_lo_im,
  output logic [TW_ADDR_W-1:0]        tw_addr,
  input  logic signed [TW_WIDTH-1:0]  tw_re,
  input  logic signed [TW_WIDTH-1:0]  tw_im,
  output logic                        out_valid,
  output logic                        out_frame,
  output logic signed [WIDTH-1:0]     out_up_re,
  output logic signed [WIDTH-1:0]     out_up_im,
  output logic signed [WIDTH-1:0]     out_lo_re,
  output logic signed [WIDTH-1:0]     out_lo_im
);
  localparam int CW = $clog2(2 * DELAY);
  localparam int AW = CW - 1;
  localparam int PW = WIDTH + TW_WIDTH + 2;
  localparam logic signed [PW-1:0] SMAX = PW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN = -SMAX - PW'(1);
  localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_FRAC - 1));

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] x);
    sat = x > SMAX ? SMAX[WIDTH-1:0] : x < SMIN ? SMIN[WIDTH-1:0] : x[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] fit(input logic signed [PW-1:0] x, input logic sc);
    fit = sc ? sat((x + PW'(1)) >>> 1) : sat(x);
  endfunction

  logic [CW-1:0] cnt;
  logic primed;
  logic signed [WIDTH-1:0] dl_re [DELAY];
  logic signed [WIDTH-1:0] dl_im [DELAY];
  logic phase;
  logic signed [WIDTH-1:0] cu_re, cu_im, cl_re, cl_im, ud_re, ud_im;
  logic signed [WIDTH-1:0] su_re, su_im, dp_re, dp_im, pl_re, pl_im;
  logic signed [PW-1:0] p_re, p_im;

  always_comb begin
    phase = cnt[CW-1];
    cu_re = phase ? in_lo_re : in_up_re;
    cu_im = phase ? in_lo_im : in_up_im;
    cl_re = phase ? in_up_re : in_lo_re;
    cl_im = phase ? in_up_im : in_lo_im;
    ud_re = dl_re[DELAY-1];
    ud_im = dl_im[DELAY-1];
    su_re = fit(PW'(ud_re) + PW'(cl_re), scale_en);
    su_im = fit(PW'(ud_im) + PW'(cl_im), scale_en);
    dp_re = fit(PW'(ud_re) - PW'(cl_re), scale_en);
    dp_im = fit(PW'(ud_im) - PW'(cl_im), scale_en);
    p_re = PW'(dp_re) * PW'(tw_re) - PW'(dp_im) * PW'(tw_im);
    p_im = PW'(dp_re) * PW'(tw_im) + PW'(dp_im) * PW'(tw_re);
    pl_re = sat((p_re + RND) >>> TW_FRAC);
    pl_im = sat((p_im + RND) >>> TW_FRAC);
    tw_addr = TW_ADDR_W'(cnt[AW-1:0] * TW_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      primed <= 1'b0;
      for (int i = 0; i < DELAY; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
      out_valid <= 1'b0;
      out_frame <= 1'b0;
      out_up_re <= '0;
      out_up_im <= '0;
      out_lo_re <= '0;
      out_lo_im <= '0;
    end else begin
      out_valid <= in_valid & primed;
      out_frame <= in_valid & primed & (cnt == '0);
      if (in_valid) begin
        cnt <= cnt + CW'(1);
        primed <= primed | (cnt == CW'(DELAY - 1));
        dl_re[0] <= cu_re;
        dl_im[0] <= cu_im;
        for (int i = 1; i < DELAY; i++) begin
          dl_re[i] <= dl_re[i-1];
          dl_im[i] <= dl_im[i-1];
        end
        if (primed) begin
          out_up_re <= su_re;
          out_up_im <= su_im;
          out_lo_re <= pl_re;
          out_lo_im <= pl_im;
        end
      end
    end
  end
endmodule
